// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller: interval and
// register-select codes, default durations and the timer state encoding.
package traffic_pkg;

  // Duration select driven by the light-sequencing FSM
  typedef enum logic [1:0] {
    TB   = 2'b00,
    TE   = 2'b01,
    TY   = 2'b10,
    TBX2 = 2'b11
  } interval_e;

  // Register select for a duration write; PS_NONE leaves all registers alone
  typedef enum logic [1:0] {
    PS_TBASE = 2'b00,
    PS_TEXT  = 2'b01,
    PS_TYEL  = 2'b10,
    PS_NONE  = 2'b11
  } param_sel_e;

  // Default durations in seconds
  localparam int DEF_TBASE_S = 6;
  localparam int DEF_TEXT_S  = 3;
  localparam int DEF_TYEL_S  = 2;

  // Timer states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A zero-second duration would never expire, so it is stored as one second
  function automatic logic [3:0] clamp_duration(input logic [3:0] value);
    return (value == 4'd0) ? 4'd1 : value;
  endfunction

endpackage

// File: rtl/one_hz_prescaler.sv
// Divides clk down to a once-per-second tick while the timer is running.
// tick is asserted combinationally during the last cycle of each second so
// the parent can register its own outputs on the wrapping edge.
module one_hz_prescaler #(
  parameter int CLK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Counter: cleared on restart, held at zero when idle, wraps at LAST
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (clear || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/interval_timer.sv
// Programmable countdown timer: holds tBASE/tEXT/tYEL, loads the selected
// duration on start_timer and counts whole seconds down to an expired pulse.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int CLK_DIV   = 1_000_000,
  parameter int DEF_TBASE = DEF_TBASE_S,
  parameter int DEF_TEXT  = DEF_TEXT_S,
  parameter int DEF_TYEL  = DEF_TYEL_S
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       Reprog_Sync,
  input  logic [1:0] Time_Param_Sel,
  input  logic [3:0] Time_Value,
  output logic       expired,
  output logic [4:0] time_left,
  output logic       tick_1hz
);

  logic [3:0] tbase, text, tyel;
  logic [3:0] wr_val;
  logic [3:0] eff_tbase, eff_text, eff_yel;
  logic [4:0] load_n;
  logic       sec_tick;
  logic       final_tick;
  state_e     state, state_next;

  assign wr_val = clamp_duration(Time_Value);

  // Duration register file with zero clamping on write
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tbase <= 4'(DEF_TBASE);
      text  <= 4'(DEF_TEXT);
      tyel  <= 4'(DEF_TYEL);
    end else if (Reprog_Sync) begin
      case (Time_Param_Sel)
        PS_TBASE: tbase <= wr_val;
        PS_TEXT:  text  <= wr_val;
        PS_TYEL:  tyel  <= wr_val;
        default:  ;
      endcase
    end
  end

  // Write-through bypass and load-value select so a same-cycle write is seen
  always_comb begin
    eff_tbase = tbase;
    eff_text  = text;
    eff_yel   = tyel;
    load_n    = 5'd0;
    if (Reprog_Sync) begin
      case (Time_Param_Sel)
        PS_TBASE: eff_tbase = wr_val;
        PS_TEXT:  eff_text  = wr_val;
        PS_TYEL:  eff_yel   = wr_val;
        default:  ;
      endcase
    end
    case (interval)
      TB:      load_n = {1'b0, eff_tbase};
      TE:      load_n = {1'b0, eff_text};
      TY:      load_n = {1'b0, eff_yel};
      default: load_n = {eff_tbase, 1'b0};
    endcase
  end

  one_hz_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .Reset_n (Reset_n),
    .clear   (start_timer),
    .run     (state == RUN),
    .tick    (sec_tick)
  );

  assign final_tick = (state == RUN) && sec_tick && (time_left == 5'd1);

  // State register
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: any start (re)enters RUN; the last second returns to IDLE
  always_comb begin
    state_next = state;
    if (start_timer) begin
      state_next = RUN;
    end else if (final_tick) begin
      state_next = IDLE;
    end
  end

  // Registered outputs: countdown value, per-second tick and expiry pulse
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      time_left <= 5'd0;
      tick_1hz  <= 1'b0;
      expired   <= 1'b0;
    end else begin
      tick_1hz <= (state == RUN) && sec_tick;
      expired  <= final_tick && !start_timer;
      if (start_timer) begin
        time_left <= load_n;
      end else if ((state == RUN) && sec_tick) begin
        time_left <= time_left - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer with CLK_DIV = 4: directed scenarios
// followed by random traffic, all compared each cycle against a model that
// works from the start edge, load value and elapsed-cycle arithmetic.
module tb_interval_timer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start_timer = 1'b0;
  logic [1:0] interval = 2'd0;
  logic       Reprog_Sync = 1'b0;
  logic [1:0] Time_Param_Sel = 2'd3;
  logic [3:0] Time_Value = 4'd0;
  logic       expired;
  logic [4:0] time_left;
  logic       tick_1hz;

  int checks = 0;
  int errors = 0;

  // Model state
  int cyc = 0;
  int m_reg [3];
  bit m_run = 0;
  int m_c0 = 0;
  int m_n = 0;
  bit e_tick = 0;
  bit e_exp = 0;
  int e_tl = 0;

  interval_timer #(
    .CLK_DIV (DIV)
  ) dut (
    .clk            (clk),
    .Reset_n        (Reset_n),
    .start_timer    (start_timer),
    .interval       (interval),
    .Reprog_Sync    (Reprog_Sync),
    .Time_Param_Sel (Time_Param_Sel),
    .Time_Value     (Time_Value),
    .expired        (expired),
    .time_left      (time_left),
    .tick_1hz       (tick_1hz)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_reg[0] = 6;
    m_reg[1] = 3;
    m_reg[2] = 2;
    m_run = 0;
    e_tick = 0;
    e_exp = 0;
    e_tl = 0;
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (tick_1hz === e_tick) else begin
      errors++;
      $error("FAIL %s tick_1hz cyc=%0d got %b want %b", tag, cyc, tick_1hz, e_tick);
    end
    checks++;
    assert (expired === e_exp) else begin
      errors++;
      $error("FAIL %s expired cyc=%0d got %b want %b", tag, cyc, expired, e_exp);
    end
    checks++;
    assert (time_left === 5'(e_tl)) else begin
      errors++;
      $error("FAIL %s time_left cyc=%0d got %0d want %0d", tag, cyc, time_left, e_tl);
    end
  endtask

  // One clock with the given inputs; model the edge and check after it
  task automatic step(input bit st, input bit [1:0] iv, input bit rp,
                      input bit [1:0] sel, input bit [3:0] val, input string tag);
    int n;
    int el;
    start_timer = st;
    interval = iv;
    Reprog_Sync = rp;
    Time_Param_Sel = sel;
    Time_Value = val;
    @(posedge clk);
    cyc++;
    // register write first, so a same-edge start sees the new value
    if (rp && sel != 2'd3) m_reg[sel] = (val == 0) ? 1 : int'(val);
    el = cyc - m_c0;
    e_tick = m_run && el > 0 && (el % DIV) == 0;
    e_exp = e_tick && (el / DIV) == m_n && !st;
    if (st) begin
      n = (iv == 2'd3) ? 2 * m_reg[0] : m_reg[iv];
      m_run = 1;
      m_c0 = cyc;
      m_n = n;
    end else if (e_tick && (el / DIV) == m_n) begin
      m_run = 0;
    end
    e_tl = m_run ? m_n - (cyc - m_c0) / DIV : 0;
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 2'd0, 0, 2'd3, 4'd0, tag);
  endtask

  // Asynchronous reset asserted away from the clock edge
  task automatic do_reset(input string tag);
    start_timer = 0;
    Reprog_Sync = 0;
    Reset_n = 0;
    #1;
    model_reset();
    check_outputs(tag);
    @(posedge clk);
    cyc++;
    #1;
    check_outputs(tag);
    Reset_n = 1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset("reset");
    idle(2, "post_reset");

    // tBASE: 6 seconds, expiry 24 cycles after start
    step(1, 2'd0, 0, 2'd3, 4'd0, "start_tb");
    idle(30, "run_tb");
    // 2 x tBASE: 12 seconds
    step(1, 2'd3, 0, 2'd3, 4'd0, "start_x2");
    idle(52, "run_x2");
    // tYEL: 2 seconds
    step(1, 2'd2, 0, 2'd3, 4'd0, "start_ty");
    idle(10, "run_ty");
    // tEXT written as 0 is clamped to 1
    step(0, 2'd0, 1, 2'd1, 4'd0, "wr_text0");
    step(1, 2'd1, 0, 2'd3, 4'd0, "start_te");
    idle(6, "run_te");
    // select 11 writes nothing; tBASE still 6
    step(0, 2'd0, 1, 2'd3, 4'd9, "wr_none");
    step(1, 2'd0, 0, 2'd3, 4'd0, "start_tb2");
    idle(27, "run_tb2");
    // restart at cycle 10 of a tBASE count
    step(1, 2'd0, 0, 2'd3, 4'd0, "restart_a");
    idle(9, "restart_run");
    step(1, 2'd0, 0, 2'd3, 4'd0, "restart_b");
    idle(28, "restart_tail");
    // start on the final tick with a same-cycle tYEL=5 write
    step(1, 2'd2, 0, 2'd3, 4'd0, "coin_a");
    idle(7, "coin_run");
    step(1, 2'd2, 1, 2'd2, 4'd5, "coin_b");
    idle(22, "coin_tail");
    // write during a count does not disturb it
    step(1, 2'd1, 0, 2'd3, 4'd0, "wr_run_a");
    step(0, 2'd0, 1, 2'd1, 4'd7, "wr_run_w");
    idle(6, "wr_run_tail");
    // reset mid-count, then tBASE back to 6
    step(0, 2'd0, 1, 2'd0, 4'd9, "wr_tb9");
    step(1, 2'd0, 0, 2'd3, 4'd0, "rst_start");
    idle(10, "rst_run");
    do_reset("rst_mid");
    idle(40, "rst_after");
    step(1, 2'd0, 0, 2'd3, 4'd0, "rst_restart");
    idle(26, "rst_restart_run");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit st, rp;
      bit [1:0] iv, sel;
      bit [3:0] val;
      st = ($urandom_range(0, 29) == 0);
      rp = ($urandom_range(0, 14) == 0);
      iv = 2'($urandom_range(0, 3));
      sel = 2'($urandom_range(0, 3));
      val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 999) == 0) do_reset("rand_rst");
      else step(st, iv, rp, sel, val, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
